// File: rtl/lake_lane_pkg.sv
// lake_lane_pkg: shared defaults and lane state encoding for the lake lane pipe
package lake_lane_pkg;
  localparam int DEF_NUM_LANES   = 2;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_COUNT_WIDTH = 8;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} lane_state_t;
  function automatic lane_state_t lane_state(input logic main_v, input logic skid_v);
    return skid_v ? FULL : (main_v ? ONE : EMPTY);
  endfunction
endpackage

// File: rtl/lake_lane_skid.sv
// lake_lane_skid: one lane with 2-entry skid buffer, lane enable and saturating transfer counter
module lake_lane_skid
  import lake_lane_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  input  logic                   i_en,
  input  logic                   i_clr,
  output logic [COUNT_WIDTH-1:0] o_count
);
  logic                   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0]  main_q, main_d, skid_q, skid_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   in_hs, out_hs, load_main, load_skid;
  lane_state_t            state;
  // A disabled lane sinks input and drops everything buffered at the next edge.
  always_comb begin
    o_ready      = !skid_valid_q || !i_en;
    in_hs        = i_valid && o_ready && i_en;
    out_hs       = main_valid_q && i_ready && i_en;
    load_main    = i_en && (skid_valid_q ? out_hs : in_hs && (!main_valid_q || out_hs));
    load_skid    = i_en && !skid_valid_q && main_valid_q && in_hs && !out_hs;
    main_valid_d = i_en && (skid_valid_q || in_hs || (main_valid_q && !out_hs));
    skid_valid_d = i_en && (skid_valid_q ? !out_hs : load_skid);
    main_d       = load_main ? (skid_valid_q ? skid_q : i_data) : main_q;
    skid_d       = load_skid ? i_data : skid_q;
    count_d      = i_clr ? '0 : (out_hs && count_q != '1) ? count_q + 1'b1 : count_q;
    state        = lane_state(main_valid_q, skid_valid_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      count_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      count_q      <= count_d;
    end
  end
  always_ff @(posedge clk) if (!rst) assert (state != FULL || main_valid_q);
  assign o_data  = main_q;
  assign o_valid = main_valid_q;
  assign o_count = count_q;
endmodule

// File: rtl/lake_lane_pipe.sv
// lake_lane_pipe: NUM_LANES independent registered valid/ready lanes on packed buses
module lake_lane_pipe
  import lake_lane_pkg::*;
#(
  parameter int NUM_LANES   = DEF_NUM_LANES,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]  i_data_in,
  input  logic [NUM_LANES-1:0]             i_valid,
  output logic [NUM_LANES-1:0]             o_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0]  o_data_out,
  output logic [NUM_LANES-1:0]             o_valid,
  input  logic [NUM_LANES-1:0]             i_ready,
  input  logic [NUM_LANES-1:0]             i_lane_en,
  input  logic                             i_count_clr,
  output logic [NUM_LANES*COUNT_WIDTH-1:0] o_count
);
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lake_lane_skid #(
      .DATA_WIDTH (DATA_WIDTH),
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_data (i_data_in[k*DATA_WIDTH +: DATA_WIDTH]),
      .i_valid(i_valid[k]),
      .o_ready(o_ready[k]),
      .o_data (o_data_out[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_valid(o_valid[k]),
      .i_ready(i_ready[k]),
      .i_en   (i_lane_en[k]),
      .i_clr  (i_count_clr),
      .o_count(o_count[k*COUNT_WIDTH +: COUNT_WIDTH])
    );
  end
endmodule

// File: tb/tb_lake_lane_pipe.sv
// tb_lake_lane_pipe: directed scoreboard bench for lake_lane_pipe (4 lanes, 16-bit data, 5-bit counters)
module tb_lake_lane_pipe;
  localparam int NL = 4;
  localparam int DW = 16;
  localparam int CW = 5;
  logic              clk = 1'b0;
  logic              rst;
  logic [NL*DW-1:0]  data_in;
  logic [NL-1:0]     i_valid, o_ready, o_valid, i_ready, lane_en;
  logic [NL*DW-1:0]  o_data_out;
  logic              count_clr;
  logic [NL*CW-1:0]  o_count;
  logic [DW-1:0]     q [NL][$];
  int                total = 0;
  int                bad = 0;

  lake_lane_pipe #(.NUM_LANES(NL), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data_in  (data_in),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data_out (o_data_out),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .i_lane_en  (lane_en),
    .i_count_clr(count_clr),
    .o_count    (o_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dout(input int k);
    return o_data_out[k*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] cnt(input int k);
    return o_count[k*CW +: CW];
  endfunction

  task automatic set_data(input int k, input logic [DW-1:0] v);
    data_in[k*DW +: DW] = v;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard update just after the inputs settle, then advance past one rising edge.
  task automatic tick();
    logic [DW-1:0] e;
    #1;
    for (int k = 0; k < NL; k++) begin
      if (rst || !lane_en[k]) q[k].delete();
      else begin
        if (o_valid[k] && i_ready[k]) begin
          chk($sformatf("lane%0d_sb_nonempty", k), 64'(q[k].size() != 0), 64'd1);
          if (q[k].size() != 0) begin
            e = q[k].pop_front();
            chk($sformatf("lane%0d_data", k), 64'(dout(k)), 64'(e));
          end
        end
        if (i_valid[k] && o_ready[k]) q[k].push_back(data_in[k*DW +: DW]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; lane_en = '1; i_valid = '0; i_ready = '0; data_in = '0; count_clr = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 64'(o_valid), 64'h0);
    chk("rst_ready", 64'(o_ready), 64'hF);
    chk("rst_count", 64'(o_count), 64'h0);
    chk("rst_data", o_data_out, 64'h0);

    i_ready = 4'b0001; i_valid = 4'b0001;
    for (int i = 1; i <= 16; i++) begin
      set_data(0, 16'(i));
      chk("stream_ready", 64'(o_ready[0]), 64'd1);
      tick();
      chk("stream_valid", 64'(o_valid[0]), 64'd1);
      chk("stream_data", 64'(dout(0)), 64'(i));
    end
    i_valid = '0;
    tick();
    chk("stream_drained", 64'(o_valid[0]), 64'd0);
    chk("stream_count", 64'(cnt(0)), 64'd16);

    i_ready = '0; i_valid = 4'b0010;
    set_data(1, 16'hAAAA);
    tick();
    set_data(1, 16'hBBBB);
    tick();
    i_valid = '0;
    chk("bp_ready_full", 64'(o_ready[1]), 64'd0);
    chk("bp_valid", 64'(o_valid[1]), 64'd1);
    chk("bp_head", 64'(dout(1)), 64'hAAAA);
    i_ready = 4'b0010;
    tick();
    chk("bp_ready_back", 64'(o_ready[1]), 64'd1);
    chk("bp_second", 64'(dout(1)), 64'hBBBB);
    tick();
    chk("bp_empty", 64'(o_valid[1]), 64'd0);
    chk("bp_count", 64'(cnt(1)), 64'd2);

    i_ready = 4'b1011; i_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NL; k++) set_data(k, 16'(k*256 + i));
      chk("indep_lane2_ready", 64'(o_ready[2]), 64'(i < 2));
      tick();
    end
    i_valid = '0;
    tick();
    chk("indep_count0", 64'(cnt(0)), 64'd22);
    chk("indep_count1", 64'(cnt(1)), 64'd8);
    chk("indep_count3", 64'(cnt(3)), 64'd6);
    chk("indep_count2", 64'(cnt(2)), 64'd0);
    chk("indep_lane2_head", 64'(dout(2)), 64'h0200);
    i_ready = '1;
    tick();
    tick();
    chk("indep_lane2_drained", 64'(o_valid[2]), 64'd0);
    chk("indep_lane2_count", 64'(cnt(2)), 64'd2);

    i_ready = '0; i_valid = 4'b0010;
    set_data(1, 16'h1111);
    tick();
    set_data(1, 16'h2222);
    tick();
    i_valid = '0;
    chk("dis_full_ready", 64'(o_ready[1]), 64'd0);
    lane_en = 4'b1101;
    tick();
    chk("dis_valid", 64'(o_valid[1]), 64'd0);
    chk("dis_ready", 64'(o_ready[1]), 64'd1);
    chk("dis_count", 64'(cnt(1)), 64'd8);
    i_valid = 4'b0010; i_ready = 4'b0010;
    set_data(1, 16'h5555);
    tick();
    chk("dis_sink_valid", 64'(o_valid[1]), 64'd0);
    chk("dis_sink_count", 64'(cnt(1)), 64'd8);
    lane_en = '1; i_ready = '0;
    set_data(1, 16'h1234);
    tick();
    i_valid = '0;
    chk("reen_valid", 64'(o_valid[1]), 64'd1);
    chk("reen_data", 64'(dout(1)), 64'h1234);
    i_ready = 4'b0010;
    tick();
    chk("reen_count", 64'(cnt(1)), 64'd9);

    i_ready = 4'b1000; i_valid = 4'b1000;
    for (int i = 0; i < 30; i++) begin
      set_data(3, 16'(16'h3000 + i));
      tick();
      if (i == 24) chk("sat_below", 64'(cnt(3)), 64'd30);
    end
    i_valid = '0;
    tick();
    chk("sat_max", 64'(cnt(3)), 64'd31);
    i_valid = 4'b1000;
    set_data(3, 16'h0077);
    tick();
    count_clr = 1'b1;
    set_data(3, 16'h0078);
    tick();
    count_clr = 1'b0; i_valid = '0;
    chk("clr_wins", 64'(cnt(3)), 64'd0);
    chk("clr_all", 64'(cnt(0)), 64'd0);
    tick();
    chk("clr_then_one", 64'(cnt(3)), 64'd1);

    i_ready = '0; i_valid = '1;
    for (int k = 0; k < NL; k++) set_data(k, 16'(16'hC000 + k));
    tick();
    tick();
    i_valid = '0;
    chk("pre_rst_full", 64'(o_ready), 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(o_valid), 64'h0);
    chk("mid_rst_count", 64'(o_count), 64'h0);
    chk("mid_rst_ready", 64'(o_ready), 64'hF);
    chk("mid_rst_data", o_data_out, 64'h0);
    i_ready = '1; i_valid = 4'b0001;
    set_data(0, 16'hBEEF);
    tick();
    i_valid = '0;
    chk("post_rst_data", 64'(dout(0)), 64'hBEEF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lake_lane_pipe.md
Name: lake_lane_pipe

Overview:
- Parametrised multi-lane registered data path. Successor to the fixed 2-lane, 1-bit passthrough top.
- Each lane carries DATA_WIDTH bits with valid/ready flow control through a 2-entry skid buffer, giving full throughput and registered data.
- Each lane has a runtime enable and a saturating transfer counter.
- Sits between the top-level data I/O and downstream memory/controller logic.

Parameters:
- NUM_LANES, 2, number of independent lanes (>=1).
- DATA_WIDTH, 16, bits per lane (>=1).
- COUNT_WIDTH, 8, width of each lane's transfer counter (>=2).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- i_data_in  input  NUM_LANES*DATA_WIDTH  lane k data at bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_valid  input  NUM_LANES  per-lane input valid.
- o_ready  output  NUM_LANES  per-lane input ready.
- o_data_out  output  NUM_LANES*DATA_WIDTH  per-lane output data, same packing as i_data_in.
- o_valid  output  NUM_LANES  per-lane output valid.
- i_ready  input  NUM_LANES  per-lane downstream ready.
- i_lane_en  input  NUM_LANES  per-lane enable (config, quasi-static).
- i_count_clr  input  1  single-cycle pulse; clears all counters.
- o_count  output  NUM_LANES*COUNT_WIDTH  per-lane transfer count, packed like data.

Behaviour:
- Reset (rst=1 at the edge): all main/skid entries invalid; o_valid=0; o_data_out=0; o_count=0. o_ready follows the combinational rule below, so it is 1 on every lane after reset.
- Lane storage: main register (drives o_data_out/o_valid) plus one skid register.
- Ready rule: o_ready[k] = !skid_valid[k] | !i_lane_en[k]. Depends only on registered state and config; no combinational path from i_ready.
- Input handshake: i_valid & o_ready. Output handshake: o_valid & i_ready.
- Latency: a word accepted at edge N appears on o_data_out at edge N (visible the following cycle). Minimum 1-cycle latency; throughput 1 word/cycle/lane with i_ready held high.
- Per-lane state: EMPTY (main invalid), ONE (main valid, skid invalid), FULL (both valid).
  - EMPTY + in_hs -> ONE; main <= input.
  - ONE + in_hs + out_hs -> ONE; main <= input.
  - ONE + in_hs + !out_hs -> FULL; skid <= input.
  - ONE + !in_hs + out_hs -> EMPTY.
  - FULL + out_hs -> ONE; main <= skid. No input is accepted because o_ready=0.
  - All other cases hold state.
- Ordering: strict FIFO per lane; no word is dropped or duplicated while enabled.
- o_data_out holds its last value when o_valid=0. It is not cleared, except by reset.
- Lane disable (i_lane_en[k]=0):
  - Main and skid are invalidated at the next edge; buffered data is discarded.
  - o_valid[k]=0 from the next cycle.
  - o_ready[k]=1, and input words are sunk and discarded.
  - The counter does not increment.
- Re-enable: the lane starts EMPTY.
- Counter: increments by 1 on each output handshake and saturates at 2^COUNT_WIDTH-1.
  - i_count_clr sets every counter to 0.
  - Clear and handshake in the same cycle: clear wins, result 0.
- Reset mid-operation: all buffered data is lost; state matches post-reset.
- Lanes are fully independent; a stall on one lane never affects another.

Decomposition:
- Package lake_lane_pkg holds:
  - default parameter constants;
  - enum lane_state_t {EMPTY, ONE, FULL}, used for assertions/debug only. The state is derived from the two valid bits.
- Sub-module lake_lane_skid: one lane containing the skid buffer, enable handling and saturating counter.
- Top instantiates it NUM_LANES times in a generate loop and slices the packed buses.

Test Plan:
- Streaming: lane 0 enabled, i_ready=1, inputs 0x0001..0x0010 on consecutive cycles -> outputs appear in order, one cycle later each, o_ready stays 1, count=16.
- Backpressure: push 0xAAAA then 0xBBBB with i_ready=0 -> lane FULL, o_ready=0, o_data_out=0xAAAA. Raise i_ready -> 0xAAAA then 0xBBBB, o_ready returns to 1 after the first pop.
- Lane independence: NUM_LANES=4, lane 2 i_ready=0, others streaming -> lanes 0/1/3 keep 1 word/cycle; lane 2 stalls after 2 accepts.
- Disable mid-stream: lane 1 FULL, drop i_lane_en[1] -> next cycle o_valid[1]=0, o_ready[1]=1, count frozen. Re-enable and push 0x1234 -> output 0x1234 one cycle later.
- Counter saturation/clear: COUNT_WIDTH=2, 5 transfers -> count=3. Pulse i_count_clr coincident with a handshake -> count=0; next transfer -> 1.
- Reset mid-operation: lanes FULL, assert rst for one cycle -> o_valid=0, o_count=0, o_ready=1 on all lanes the following cycle.
